apb_master_arbiter: RTL and testbench
=====================================

# apb_master_arbiter

Two-requester APB master that shares one APB bus between the AHB slave interface path and a second on-chip requester, such as a DMA or debug port. It arbitrates round-robin and sequences APB SETUP/ACCESS phases with Pready wait states and a wait-state timeout. It decodes one-hot Pselx for four peripherals and returns read data, response and completion to the granted requester.

## Interface
- ADDR_W, 32, address width (Paddr, addr0/1)
- DATA_W, 32, data width
- SEL_LSB, 12, LSB of 2-bit peripheral index field in address; must satisfy SEL_LSB+1 < ADDR_W
- TIMEOUT, 16, max ACCESS cycles per transfer (>=1)
- Hclk  in  1  clock, all state on rising edge
- Hresetn  in  1  asynchronous, active-low reset
- req0 / req1  in  1  transfer request; held with fields stable until matching ack
- write0 / write1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  transfer address
- wdata0 / wdata1  in  DATA_W  write data
- ack0 / ack1  out  1  one-cycle completion strobe (combinational)
- rdata0 / rdata1  out  DATA_W  read data, valid only while own ack high
- err0 / err1  out  1  error response, valid only while own ack high
- Pselx  out  4  one-hot peripheral select
- Paddr  out  ADDR_W  APB address
- Pwrite  out  1  APB direction
- Penable  out  1  APB enable
- Pwdata  out  DATA_W  APB write data
- Prdata  in  DATA_W  APB read data
- Pready  in  1  APB ready
- Pslverr  in  1  APB slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - With no req: stay in IDLE.
  - With any req: grant, latch the granted addr/write/wdata into Paddr/Pwrite/Pwdata, go to SETUP.
- Arbitration:
  - Single request wins.
  - Both requesting: grant the requester that was not last granted.
  - last_grant updates on each grant. Reset value is 1, so req0 wins the first tie.
- SETUP: Pselx[Paddr[SEL_LSB+:2]] = 1, Penable = 0; unconditionally go to ACCESS.
- ACCESS:
  - Pselx held, Penable = 1.
  - Completion occurs when Pready = 1, or on timeout.
  - On completion, go to IDLE. Pselx and Penable drop to 0 the next cycle.
- Completion outputs:
  - ackN = (state==ACCESS) & (grant==N) & (Pready | tmo).
  - rdataN = Prdata on normal completion, 0 on timeout.
  - errN = Pslverr on normal completion, 1 on timeout.
  - Non-granted ack, rdata and err are 0.
- Timeout:
  - wait counter width clog2(TIMEOUT)+1; cleared on SETUP->ACCESS; increments each ACCESS cycle with Pready = 0.
  - tmo = (count == TIMEOUT-1) & ~Pready, so ACCESS never exceeds TIMEOUT cycles.
- Paddr/Pwrite/Pwdata hold their last values in IDLE. Pselx is 0 in IDLE.
- Pwdata is driven for reads as well (latched wdata); peripherals ignore it.
- Requester protocol: drop req or present a new request in the cycle after ack. A req already high in IDLE is taken as a new request.
- Reset (asynchronous, any state):
  - State IDLE; Pselx, Penable, Pwrite, Paddr, Pwdata, counter = 0; last_grant = 1.
  - No ack is generated for an aborted transfer.

## Timing
- req sampled high in IDLE at edge T0 -> SETUP in cycle after T0 -> ACCESS the following cycle.
- Zero-wait transfer: 3 cycles from grant edge to return to IDLE (IDLE, SETUP, ACCESS). Ack is high during the ACCESS cycle.
- Back-to-back minimum: 3 cycles per transfer; Pselx deasserts for one IDLE cycle between transfers.
- Each Pready=0 cycle in ACCESS adds one cycle, up to TIMEOUT ACCESS cycles total.
- Pselx, Paddr, Pwrite and Pwdata are stable from SETUP through the final ACCESS cycle.
- Outputs Pselx, Penable, Paddr, Pwrite and Pwdata are registered. ack, rdata and err are combinational from state, Pready, Prdata and Pslverr.

## Test plan
- Write via req0:
  - Stimulus: addr0 = 0x0000_2004, wdata0 = 0xDEADBEEF, Pready = 1.
  - Required: Pselx = 4'b0100 in SETUP and ACCESS; Penable high only in ACCESS; Pwdata = 0xDEADBEEF; ack0 high for exactly 1 cycle; ack1 = 0.
- Read via req1:
  - Stimulus: addr1 = 0x0000_3000, Prdata = 0x1234_5678, Pready low for 3 ACCESS cycles then high.
  - Required: ACCESS lasts 4 cycles; ack1 with rdata1 = 0x1234_5678, err1 = 0.
- Tie arbitration:
  - Stimulus: req0 and req1 held high continuously out of reset.
  - Required: grant order 0,1,0,1; each transfer 3 cycles with Pready = 1.
- Timeout:
  - Stimulus: TIMEOUT = 16, Pready stuck 0.
  - Required: ack after exactly 16 ACCESS cycles; err = 1, rdata = 0; FSM returns to IDLE.
- Slave error:
  - Stimulus: Pslverr = 1 with Pready = 1 on a write.
  - Required: err0 = 1 on ack0; the next transfer proceeds normally.
- Reset mid-transfer:
  - Stimulus: Hresetn low during a wait-stated ACCESS.
  - Required: Pselx, Penable = 0 immediately; no ack. After release, a tie goes to req0.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master with round-robin arbitration, one-hot peripheral
// select, Pready wait states and an ACCESS-phase wait-state timeout.
module apb_master_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SEL_LSB = 12,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              req0,
    input  logic              write0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    output logic              err0,
    input  logic              req1,
    input  logic              write1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic              err1,
    output logic [3:0]        Pselx,
    output logic [ADDR_W-1:0] Paddr,
    output logic              Pwrite,
    output logic              Penable,
    output logic [DATA_W-1:0] Pwdata,
    input  logic [DATA_W-1:0] Prdata,
    input  logic              Pready,
    input  logic              Pslverr
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

    state_t            state, next_state;
    logic              last_grant, next_grant, pick;
    logic [CNT_W-1:0]  count, next_count;
    logic [3:0]        next_sel;
    logic              next_enable, next_write;
    logic [ADDR_W-1:0] new_addr, next_addr;
    logic [DATA_W-1:0] next_wdata;
    logic              tmo, done;

    // last_grant doubles as the current grant while a transfer is in flight.
    assign pick     = (req0 && req1) ? ~last_grant : req1;
    assign new_addr = pick ? addr1 : addr0;
    assign tmo      = (state == ACCESS) && (count == CNT_W'(TIMEOUT - 1)) && !Pready;
    assign done     = (state == ACCESS) && (Pready || tmo);

    assign ack0   = done && !last_grant;
    assign ack1   = done && last_grant;
    assign rdata0 = (ack0 && Pready) ? Prdata : '0;
    assign rdata1 = (ack1 && Pready) ? Prdata : '0;
    assign err0   = ack0 && (Pready ? Pslverr : 1'b1);
    assign err1   = ack1 && (Pready ? Pslverr : 1'b1);

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            last_grant <= 1'b1;
            count      <= '0;
            Pselx      <= '0;
            Penable    <= 1'b0;
            Pwrite     <= 1'b0;
            Paddr      <= '0;
            Pwdata     <= '0;
        end else begin
            last_grant <= next_grant;
            count      <= next_count;
            Pselx      <= next_sel;
            Penable    <= next_enable;
            Pwrite     <= next_write;
            Paddr      <= next_addr;
            Pwdata     <= next_wdata;
        end
    end

    always_comb begin
        next_state  = state;
        next_grant  = last_grant;
        next_count  = count;
        next_sel    = Pselx;
        next_enable = Penable;
        next_write  = Pwrite;
        next_addr   = Paddr;
        next_wdata  = Pwdata;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    next_grant = pick;
                    next_addr  = new_addr;
                    next_write = pick ? write1 : write0;
                    next_wdata = pick ? wdata1 : wdata0;
                    next_sel   = 4'b0001 << new_addr[SEL_LSB +: 2];
                    next_state = SETUP;
                end
            end
            SETUP: begin
                next_enable = 1'b1;
                next_count  = '0;
                next_state  = ACCESS;
            end
            ACCESS: begin
                if (done) begin
                    next_sel    = '0;
                    next_enable = 1'b0;
                    next_state  = IDLE;
                end else begin
                    next_count = count + CNT_W'(1);
                end
            end
            default: next_state = IDLE;
        endcase
    end
endmodule

// File: tb/tb_apb_master_arbiter.sv
// Scoreboard bench for apb_master_arbiter: a small APB slave model with
// programmable wait states, expected completions queued at request time.
module tb_apb_master_arbiter;
    localparam int unsigned TMO   = 16;
    localparam int unsigned LIMIT = 64;

    logic        Hclk, Hresetn;
    logic        req0, write0, ack0, err0;
    logic        req1, write1, ack1, err1;
    logic [31:0] addr0, wdata0, rdata0, addr1, wdata1, rdata1;
    logic [3:0]  Pselx;
    logic [31:0] Paddr, Pwdata, Prdata;
    logic        Pwrite, Penable, Pready, Pslverr;

    apb_master_arbiter #(
        .ADDR_W(32), .DATA_W(32), .SEL_LSB(12), .TIMEOUT(TMO)
    ) dut (
        .Hclk(Hclk), .Hresetn(Hresetn),
        .req0(req0), .write0(write0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0), .err0(err0),
        .req1(req1), .write1(write1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1), .err1(err1),
        .Pselx(Pselx), .Paddr(Paddr), .Pwrite(Pwrite), .Penable(Penable),
        .Pwdata(Pwdata), .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
    );

    typedef struct packed {
        logic        id;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  n;
    } exp_t;

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;
    int unsigned acc_cnt = 0;
    int unsigned acc_seen = 0;
    int unsigned wait_n = 0;
    logic        stuck = 1'b0;

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    always @(posedge Hclk) cyc <= cyc + 1;
    always @(posedge Hclk) acc_cnt <= Penable ? acc_cnt + 1 : 0;

    function automatic logic [31:0] slave_rdata(input logic [31:0] a);
        return (a == 32'h0000_3000) ? 32'h1234_5678 : (a ^ 32'hA5A5_0000);
    endfunction

    assign Pready  = !stuck && Penable && (acc_cnt >= wait_n);
    assign Prdata  = slave_rdata(Paddr);
    assign Pslverr = (Paddr[7:0] == 8'hEE);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_exp(input logic id, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        e.id    = id;
        e.addr  = a;
        e.wr    = wr;
        e.wdata = wd;
        e.rdata = stuck ? 32'h0 : slave_rdata(a);
        e.err   = stuck ? 1'b1 : (a[7:0] == 8'hEE);
        e.n     = stuck ? 8'(TMO) : 8'(wait_n + 1);
        sb.push_back(e);
    endtask

    always @(negedge Hclk) begin
        exp_t       e;
        logic [1:0] ix;
        if (Penable) acc_seen++;
        else acc_seen = 0;
        if (ack0 || ack1) begin
            check_eq("ack_excl", 32'(ack0 & ack1), 32'h0);
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_ack", 32'(sb.size()), 32'h1);
            end else begin
                e  = sb.pop_front();
                ix = e.addr[13:12];
                check_eq("ack_id", 32'(ack1), 32'(e.id));
                check_eq("rdata", ack1 ? rdata1 : rdata0, e.rdata);
                check_eq("err", 32'(ack1 ? err1 : err0), 32'(e.err));
                check_eq("other_rdata", ack1 ? rdata0 : rdata1, 32'h0);
                check_eq("access_cycles", acc_seen, 32'(e.n));
                check_eq("paddr", Paddr, e.addr);
                check_eq("pwrite", 32'(Pwrite), 32'(e.wr));
                check_eq("pwdata", Pwdata, e.wdata);
                check_eq("pselx", 32'(Pselx), 32'(4'b0001 << ix));
            end
        end
    end

    task automatic wait_ack(output logic id, output int unsigned at);
        id = 1'b0;
        at = 0;
        for (int unsigned i = 0; i < LIMIT; i++) begin
            @(negedge Hclk);
            if (ack0 || ack1) begin
                id = ack1;
                at = cyc;
                return;
            end
        end
        check_eq("ack_wait_expired", 32'h0, 32'h1);
    endtask

    task automatic do_xfer(input logic id, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        logic        gid;
        int unsigned at;
        push_exp(id, wr, a, wd);
        if (id) begin
            write1 = wr; addr1 = a; wdata1 = wd; req1 = 1'b1;
        end else begin
            write0 = wr; addr0 = a; wdata0 = wd; req0 = 1'b1;
        end
        wait_ack(gid, at);
        @(posedge Hclk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    initial begin
        logic        gid;
        int unsigned at, prev_at;

        Hresetn = 1'b0;
        write0 = 1'b1; addr0 = 32'h0000_1000; wdata0 = 32'h0000_0A0A;
        write1 = 1'b0; addr1 = 32'h0000_2100; wdata1 = 32'h0000_0B0B;
        req0 = 1'b1; req1 = 1'b1;
        repeat (2) @(negedge Hclk);
        check_eq("rst_pselx", 32'(Pselx), 32'h0);
        check_eq("rst_penable", 32'(Penable), 32'h0);
        check_eq("rst_paddr", Paddr, 32'h0);
        check_eq("rst_pwdata", Pwdata, 32'h0);
        check_eq("rst_pwrite", 32'(Pwrite), 32'h0);
        check_eq("rst_ack", 32'({ack0, ack1}), 32'h0);

        // tie out of reset: 0,1,0,1 at three-cycle spacing
        for (int k = 0; k < 4; k++) push_exp(k[0], k[0] ? 1'b0 : 1'b1, k[0] ? addr1 : addr0, k[0] ? wdata1 : wdata0);
        Hresetn = 1'b1;
        prev_at = 0;
        for (int k = 0; k < 4; k++) begin
            wait_ack(gid, at);
            check_eq("tie_order", 32'(gid), 32'(k[0]));
            if (k > 0) check_eq("tie_spacing", at - prev_at, 32'd3);
            prev_at = at;
        end
        @(posedge Hclk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge Hclk);
        #1;

        // write via req0, phase by phase
        push_exp(1'b0, 1'b1, 32'h0000_2004, 32'hDEAD_BEEF);
        write0 = 1'b1; addr0 = 32'h0000_2004; wdata0 = 32'hDEAD_BEEF; req0 = 1'b1;
        @(negedge Hclk);
        check_eq("wr_idle_pselx", 32'(Pselx), 32'h0);
        @(negedge Hclk);
        check_eq("wr_setup_pselx", 32'(Pselx), 32'h4);
        check_eq("wr_setup_penable", 32'(Penable), 32'h0);
        check_eq("wr_setup_pwdata", Pwdata, 32'hDEAD_BEEF);
        check_eq("wr_setup_ack", 32'(ack0), 32'h0);
        @(negedge Hclk);
        check_eq("wr_access_pselx", 32'(Pselx), 32'h4);
        check_eq("wr_access_penable", 32'(Penable), 32'h1);
        check_eq("wr_ack0", 32'(ack0), 32'h1);
        check_eq("wr_ack1", 32'(ack1), 32'h0);
        @(posedge Hclk);
        #1;
        req0 = 1'b0;
        @(negedge Hclk);
        check_eq("wr_ack0_once", 32'(ack0), 32'h0);
        check_eq("wr_idle_penable", 32'(Penable), 32'h0);
        check_eq("wr_idle_pselx_after", 32'(Pselx), 32'h0);
        @(posedge Hclk);
        #1;

        // read via req1 with three wait states
        wait_n = 3;
        do_xfer(1'b1, 1'b0, 32'h0000_3000, 32'h0);
        wait_n = 0;

        // slave error, then a normal transfer
        do_xfer(1'b0, 1'b1, 32'h0000_10EE, 32'h0000_0055);
        do_xfer(1'b0, 1'b1, 32'h0000_2020, 32'h0000_0066);

        // timeout with Pready stuck low
        stuck = 1'b1;
        do_xfer(1'b1, 1'b0, 32'h0000_0100, 32'h0);
        stuck = 1'b0;
        @(negedge Hclk);
        check_eq("tmo_idle_pselx", 32'(Pselx), 32'h0);
        check_eq("tmo_idle_penable", 32'(Penable), 32'h0);
        @(posedge Hclk);
        #1;

        // reset during a wait-stated ACCESS of a req0 transfer
        wait_n = 5;
        write0 = 1'b1; addr0 = 32'h0000_0010; wdata0 = 32'h0000_0077; req0 = 1'b1;
        for (int unsigned i = 0; i < 20 && !Penable; i++) @(negedge Hclk);
        check_eq("rst_mid_reached_access", 32'(Penable), 32'h1);
        @(negedge Hclk);
        #2;
        Hresetn = 1'b0;
        #1;
        check_eq("rst_mid_pselx", 32'(Pselx), 32'h0);
        check_eq("rst_mid_penable", 32'(Penable), 32'h0);
        check_eq("rst_mid_ack", 32'({ack0, ack1}), 32'h0);
        req1 = 1'b1;
        wait_n = 0;
        repeat (2) @(negedge Hclk);
        push_exp(1'b0, 1'b1, addr0, wdata0);
        push_exp(1'b1, write1, addr1, wdata1);
        Hresetn = 1'b1;
        wait_ack(gid, at);
        check_eq("rst_tie_first", 32'(gid), 32'h0);
        wait_ack(gid, at);
        check_eq("rst_tie_second", 32'(gid), 32'h1);
        @(posedge Hclk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;

        repeat (4) @(negedge Hclk);
        check_eq("sb_drain", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
